// File: rtl/sram_responder_pkg.sv
// Shared constants and helpers for the SRAM/MMIO responder.
// Holds the default memory geometry, the MMIO region base and register offsets, and the read-return select.
package sram_responder_pkg;

  localparam int          RAM_AW_DEFAULT    = 14;
  localparam logic [15:0] MMIO_BASE_DEFAULT = 16'hBFAF;

  localparam logic [15:0] OFF_TIMER  = 16'hE000;
  localparam logic [15:0] OFF_LED    = 16'hF000;
  localparam logic [15:0] OFF_NUM    = 16'hF010;
  localparam logic [15:0] OFF_SWITCH = 16'hF020;

  // Source of the word presented on sram_rdata, captured with each accepted request.
  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_TIMER,
    SEL_LED,
    SEL_NUM,
    SEL_SWITCH,
    SEL_UNMAPPED
  } rsel_e;

  function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  we);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (we[i]) res[i*8 +: 8] = wdata[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_responder_bank.sv
// Byte-enabled, read-first, single-port RAM with a registered read port (no reset).
// The read register only loads on enabled cycles, so it holds its value when idle.
module sram_bank
  import sram_responder_pkg::*;
#(
  parameter int AW = RAM_AW_DEFAULT
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];
  logic [31:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
      rdata_reg <= mem[addr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/sram_responder.sv
// SRAM-style bus responder: RAM bank plus a small MMIO block (TIMER, LED, NUM, SWITCH).
// Every accepted access returns a word one cycle later; register reads return pre-write values.
module sram_responder
  import sram_responder_pkg::*;
#(
  parameter int          RAM_AW    = RAM_AW_DEFAULT,
  parameter logic [15:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sram_en,
  input  logic [3:0]  sram_we,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  input  logic [7:0]  switch_in,
  output logic [15:0] led_out,
  output logic [31:0] num_out
);

  logic        req;
  logic        wr;
  logic        is_mmio;
  logic [15:0] offset;
  rsel_e       sel_next;
  rsel_e       sel_reg;
  logic [31:0] mmio_rdata_next;
  logic [31:0] mmio_rdata_reg;
  logic [31:0] timer_reg;
  logic [15:0] led_reg;
  logic [31:0] num_reg;
  logic [31:0] timer_merged;
  logic [31:0] led_merged;
  logic [31:0] num_merged;
  logic [31:0] bank_rdata;
  logic        bank_en;

  // Requests are gated by reset so an in-flight access never reaches the RAM.
  assign req     = sram_en & ~reset;
  assign wr      = req & (|sram_we);
  assign is_mmio = (sram_addr[31:16] == MMIO_BASE);
  assign offset  = sram_addr[15:0];
  assign bank_en = req & ~is_mmio;

  assign timer_merged = merge_bytes(timer_reg, sram_wdata, sram_we);
  assign led_merged   = merge_bytes({16'h0, led_reg}, sram_wdata, sram_we);
  assign num_merged   = merge_bytes(num_reg, sram_wdata, sram_we);

  always_comb begin
    sel_next        = SEL_RAM;
    mmio_rdata_next = 32'h0;
    if (is_mmio) begin
      case (offset)
        OFF_TIMER: begin
          sel_next        = SEL_TIMER;
          mmio_rdata_next = timer_reg;
        end
        OFF_LED: begin
          sel_next        = SEL_LED;
          mmio_rdata_next = {16'h0, led_reg};
        end
        OFF_NUM: begin
          sel_next        = SEL_NUM;
          mmio_rdata_next = num_reg;
        end
        OFF_SWITCH: begin
          sel_next        = SEL_SWITCH;
          mmio_rdata_next = {24'h0, switch_in};
        end
        default: sel_next = SEL_UNMAPPED;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_reg      <= 32'h0;
      led_reg        <= 16'h0;
      num_reg        <= 32'h0;
      sel_reg        <= SEL_NONE;
      mmio_rdata_reg <= 32'h0;
    end else begin
      // A TIMER write replaces this cycle's increment; counting resumes from the merged value.
      if (wr && sel_next == SEL_TIMER) timer_reg <= timer_merged;
      else                             timer_reg <= timer_reg + 32'd1;
      if (wr && sel_next == SEL_LED) led_reg <= led_merged[15:0];
      if (wr && sel_next == SEL_NUM) num_reg <= num_merged;
      if (req) begin
        sel_reg        <= sel_next;
        mmio_rdata_reg <= mmio_rdata_next;
      end
    end
  end

  sram_bank #(
    .AW(RAM_AW)
  ) u_bank (
    .clk  (clk),
    .en   (bank_en),
    .we   (sram_we),
    .addr (sram_addr[RAM_AW+1:2]),
    .wdata(sram_wdata),
    .rdata(bank_rdata)
  );

  // SEL_NONE after reset forces zero until the first new request returns.
  always_comb begin
    sram_rdata = 32'h0;
    case (sel_reg)
      SEL_RAM:                                   sram_rdata = bank_rdata;
      SEL_TIMER, SEL_LED, SEL_NUM, SEL_SWITCH:   sram_rdata = mmio_rdata_reg;
      default:                                   sram_rdata = 32'h0;
    endcase
  end

  assign led_out = led_reg;
  assign num_out = num_reg;

endmodule
